// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer.
// Opcodes, FSM states and the PC/WB mux selects used by the datapath.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_REL   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  typedef struct packed {
    logic       is_legal;
    logic       is_branch;
    logic       is_mem;
    logic       is_store;
    logic [1:0] wb_sel;
    logic [1:0] pc_src;
    logic       alu_src;
  } opclass_t;

endpackage

// File: rtl/multicycle_ctrl_opclass.sv
// Combinational opcode classifier for the multi-cycle sequencer.
// Unknown opcodes come out all-zero, i.e. is_legal = 0.
module multicycle_ctrl_opclass
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_t   cls
);

  always_comb begin
    cls = '0;
    unique case (1'b1)
      (opcode == OP_LUI): begin
        cls.is_legal = 1'b1;
        cls.wb_sel   = WB_IMM;
      end
      (opcode == OP_AUIPC): begin
        cls.is_legal = 1'b1;
      end
      (opcode == OP_JAL): begin
        cls.is_legal = 1'b1;
        cls.wb_sel   = WB_PC4;
        cls.pc_src   = PC_REL;
      end
      (opcode == OP_JALR): begin
        cls.is_legal = 1'b1;
        cls.wb_sel   = WB_PC4;
        cls.pc_src   = PC_JALR;
        cls.alu_src  = 1'b1;
      end
      (opcode == OP_BRANCH): begin
        cls.is_legal  = 1'b1;
        cls.is_branch = 1'b1;
        cls.pc_src    = PC_REL;
      end
      (opcode == OP_LOAD): begin
        cls.is_legal = 1'b1;
        cls.is_mem   = 1'b1;
        cls.wb_sel   = WB_LOAD;
        cls.alu_src  = 1'b1;
      end
      (opcode == OP_STORE): begin
        cls.is_legal = 1'b1;
        cls.is_mem   = 1'b1;
        cls.is_store = 1'b1;
        cls.alu_src  = 1'b1;
      end
      (opcode == OP_IMM): begin
        cls.is_legal = 1'b1;
        cls.alu_src  = 1'b1;
      end
      (opcode == OP_REG): begin
        cls.is_legal = 1'b1;
      end
      default: cls = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB strobes.
// Define MULTICYCLE_CTRL_PERF_EN to add cycle/instret counter ports.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter bit          RESET_STATE_FETCH = 1'b1,
  parameter int unsigned IMEM_TIMEOUT      = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] inst,
  input  logic        imem_valid,
  input  logic        dmem_ready,
  input  logic        br_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        alu_src,
  output logic [1:0]  wb_sel,
  output logic        rwrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        trap,
  output logic [2:0]  state
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  localparam state_t RST_STATE =
    RESET_STATE_FETCH ? S_FETCH : S_IDLE;
  localparam logic [31:0] TMO_LAST =
    32'(IMEM_TIMEOUT) - 32'd1;

  state_t      cur;
  state_t      nxt;
  opclass_t    cls;
  logic [4:0]  rd;
  logic [31:0] tmo_cnt;
  logic        tmo_hit;
  logic        unused_inst;

  assign rd          = inst[11:7];
  assign unused_inst = ^inst[31:12];
  assign state       = cur;

  multicycle_ctrl_opclass u_opclass (
    .opcode (inst[6:0]),
    .cls    (cls)
  );

  assign tmo_hit = (IMEM_TIMEOUT != 0) &&
                   (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= RST_STATE;
    end else begin
      cur <= nxt;
    end
  end

  // Zero on every entry to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (cur == S_FETCH && nxt == S_FETCH) begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_IDLE: begin
        if (start) nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_valid)   nxt = S_DECODE;
        else if (tmo_hit) nxt = S_TRAP;
      end
      S_DECODE: begin
        nxt = cls.is_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (cls.is_branch)   nxt = S_FETCH;
        else if (cls.is_mem) nxt = S_MEM;
        else                 nxt = S_WB;
      end
      S_MEM: begin
        if (dmem_ready)
          nxt = cls.is_store ? S_FETCH : S_WB;
      end
      S_WB:    nxt = S_FETCH;
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_TRAP;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = PC_PLUS4;
    alu_src  = 1'b0;
    wb_sel   = WB_ALU;
    rwrite   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    trap     = 1'b0;
    unique case (cur)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_valid;
      end
      S_EXEC: begin
        alu_src = cls.alu_src;
        if (cls.is_branch) begin
          pc_we  = 1'b1;
          pc_src = br_taken ? PC_REL : PC_PLUS4;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cls.is_store;
        pc_we    = dmem_ready && cls.is_store;
      end
      S_WB: begin
        rwrite = (rd != 5'd0);
        wb_sel = cls.wb_sel;
        pc_we  = 1'b1;
        pc_src = cls.pc_src;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
    // Reset state may be FETCH; keep every strobe quiet while held.
    if (!rst_n) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      rwrite   = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (cur != S_IDLE && cur != S_TRAP)
        cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_we)
        instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the write/select strobes for the PC, IR, register file, ALU and data memory. It sits beside the instruction-decode stage and consumes the opcode and rd fields of the latched instruction. It generates the register-write strobe at the correct cycle, instead of the level decode the decode stage produces.

Parameters:
RESET_STATE_FETCH, 1, 1 = leave reset in FETCH; 0 = leave reset in IDLE and wait for START.
IMEM_TIMEOUT, 0, 0 = no timeout; N>0 = go to TRAP after N cycles in FETCH without IMEM_VALID.

Ports:
CLK  in  1  core clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
START  in  1  leave IDLE; used only when RESET_STATE_FETCH=0.
INST  in  32  IR output; stable from DECODE until retire.
IMEM_VALID  in  1  instruction word valid this cycle.
DMEM_READY  in  1  data access complete this cycle.
BR_TAKEN  in  1  branch comparator result; sampled in EXEC.
IMEM_REQ  out  1  instruction fetch request.
IR_WE  out  1  load IR.
PC_WE  out  1  update PC; one-cycle pulse at retire.
PC_SRC  out  2  00 pc+4, 01 pc+imm, 10 (rs1+imm)&~1.
ALU_SRC  out  1  0 rs2, 1 imm.
WB_SEL  out  2  00 ALU, 01 load data, 10 pc+4, 11 imm.
RWRITE  out  1  register-file write strobe.
DMEM_REQ  out  1  data request.
DMEM_WE  out  1  data write (store).
TRAP  out  1  illegal opcode or fetch timeout; sticky.
STATE  out  3  current state, for debug.

Behaviour:
- Reset (async, RST_N=0): state = FETCH, or IDLE when RESET_STATE_FETCH=0. All strobes are 0, PC_SRC/WB_SEL are 00, TRAP=0.
- Outputs are Moore-decoded from the state register plus INST[6:0] and INST[11:7]. No combinational path exists from IMEM_VALID or DMEM_READY to any output except IR_WE and PC_WE, as listed below.
- Opcodes: lui 0110111, auipc 0010111, jal 1101111, jalr 1100111, branch 1100011, load 0000011, store 0100011, I_op 0010011, R_op 0110011. Any other opcode is illegal.
- IDLE: all outputs 0. START=1 moves to FETCH.
- FETCH: IMEM_REQ=1, held until IMEM_VALID. In the IMEM_VALID cycle IR_WE=1, and the next state is DECODE.
- DECODE: one cycle. An illegal opcode goes to TRAP; every legal opcode goes to EXEC.
- EXEC: ALU_SRC=1 for I_op, load, store and jalr, otherwise 0.
  - Branch: PC_WE=1, PC_SRC = BR_TAKEN ? 01 : 00, next state FETCH.
  - Load or store: next state MEM.
  - All other legal opcodes: next state WB.
- MEM: DMEM_REQ=1 (and DMEM_WE=1 for store) held until DMEM_READY.
  - On DMEM_READY for a store: PC_WE=1, PC_SRC=00, next state FETCH.
  - On DMEM_READY for a load: next state WB.
- WB:
  - RWRITE=1 unless rd=0. A write to x0 is suppressed here.
  - WB_SEL is 11 for lui, 10 for jal and jalr, 01 for load, otherwise 00.
  - PC_WE=1. PC_SRC is 01 for jal, 10 for jalr, otherwise 00.
  - Next state FETCH.
- TRAP: all strobes 0 and TRAP=1 until reset.
- Latency, fetch-to-retire with zero-wait memories: branch 3 cycles; R_op, I_op, lui, auipc, jal and jalr 4 cycles; store 4 cycles; load 5 cycles.
- Exactly one PC_WE pulse per retired instruction. RWRITE is never asserted outside WB.
- Asynchronous reset mid-MEM or mid-FETCH drops the request immediately. No partial retire occurs.
- IMEM_TIMEOUT counter clears on entry to FETCH. When the count reaches N, the next state is TRAP.

Optional Feature:
MULTICYCLE_CTRL_PERF_EN.
- Defined: adds 32-bit counters CYCLE_CNT and INSTRET_CNT as outputs. Both reset to 0 and wrap at 2^32.
  - CYCLE_CNT increments every cycle outside IDLE and TRAP.
  - INSTRET_CNT increments on each PC_WE pulse.
- Undefined: no counters and no ports.

Decomposition:
- Shared package/defines file holds the opcode constants (lui, auipc, jal, jalr, branch, load, store, I_op, R_op) and the state encoding: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- It also holds the PC_SRC and WB_SEL encodings, which the datapath muxes use as well.
- One natural sub-module: ctrl_opclass, a combinational map from opcode to {is_legal, is_branch, is_mem, is_store, wb_sel, pc_src, alu_src}.

Test Plan:
- R_op add x5 (0x00A282B3), IMEM_VALID and DMEM_READY tied to 1 → states FETCH, DECODE, EXEC, WB. RWRITE=1 and WB_SEL=00 in cycle 4. PC_WE pulses once, PC_SRC=00.
- Load lw x6 (0x0002A303), DMEM_READY delayed 3 cycles → DMEM_REQ held 4 cycles with DMEM_WE=0. Then WB with WB_SEL=01 and RWRITE=1. Total 8 cycles.
- Branch beq with BR_TAKEN=1, then BR_TAKEN=0 → retire in EXEC with PC_SRC=01, then 00. RWRITE stays 0.
- jalr x1 (0x000080E7) → WB_SEL=10, PC_SRC=10, RWRITE=1. Then addi x0 (0x00100013) → RWRITE stays 0.
- Illegal opcode 0x0000007F → TRAP=1 after DECODE, no PC_WE. Stays in TRAP until RST_N=0.
- RST_N asserted low mid-MEM of a store → DMEM_REQ, DMEM_WE and STATE clear the same cycle with no PC_WE. After release the FSM resumes in FETCH.
